// File: rtl/expr_eval.sv
// Streaming recogniser/evaluator for ASCII "num (op num)*" expressions.
// It gives '*' precedence over '+'/'-' and uses one accumulate step per character.
module expr_eval #(
  parameter int WIDTH       = 32,
  parameter int MAX_DIGITS  = 4,
  parameter int ALLOW_MINUS = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic signed [WIDTH-1:0] NEG_ONE = '1;
  localparam logic signed [WIDTH-1:0] TEN     = WIDTH'(10);

  typedef enum logic [1:0] {INIT, NUM, OPR, FAIL} state_t;

  state_t                   state, state_nxt;
  logic signed [WIDTH-1:0]  sum, sum_nxt;
  logic signed [WIDTH-1:0]  prod, prod_nxt;
  logic signed [WIDTH-1:0]  num, num_nxt;
  logic signed [WIDTH-1:0]  res, res_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;

  logic                     is_digit, is_mul, is_add, is_sub;
  logic signed [WIDTH-1:0]  dig, num_x10;

  // Modular multiply-accumulate; truncation to WIDTH is the intended wrap.
  function automatic logic signed [WIDTH-1:0] mac(
    input logic signed [WIDTH-1:0] s,
    input logic signed [WIDTH-1:0] p,
    input logic signed [WIDTH-1:0] n
  );
    return s + p * n;
  endfunction

  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_mul   = (in == 8'h2a);
    is_add   = (in == 8'h2b);
    is_sub   = (in == 8'h2d) && (ALLOW_MINUS != 0);
    dig      = '0;
    dig[3:0] = in[3:0];
    num_x10  = num * TEN + dig;
  end

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    prod_nxt  = prod;
    num_nxt   = num;
    cnt_nxt   = cnt;
    res_nxt   = res;
    if (in_valid) begin
      case (state)
        INIT, OPR: begin
          if (is_digit) begin
            state_nxt = NUM;
            num_nxt   = dig;
            cnt_nxt   = CNT_W'(1);
            res_nxt   = mac(sum, prod, dig);
          end else begin
            state_nxt = FAIL;
          end
        end
        NUM: begin
          if (is_digit) begin
            if (cnt < CNT_MAX) begin
              num_nxt = num_x10;
              cnt_nxt = cnt + CNT_W'(1);
              res_nxt = mac(sum, prod, num_x10);
            end else begin
              state_nxt = FAIL;
            end
          end else if (is_mul || is_add || is_sub) begin
            state_nxt = OPR;
            num_nxt   = '0;
            cnt_nxt   = '0;
            if (is_mul) begin
              prod_nxt = prod * num;
            end else begin
              // Closing a term: the sign of the next term rides in prod.
              sum_nxt  = mac(sum, prod, num);
              prod_nxt = is_sub ? NEG_ONE : ONE;
            end
          end else begin
            state_nxt = FAIL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= INIT;
      sum   <= '0;
      prod  <= ONE;
      num   <= '0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      sum   <= sum_nxt;
      prod  <= prod_nxt;
      num   <= num_nxt;
      cnt   <= cnt_nxt;
      res   <= res_nxt;
    end
  end

  assign out    = (state == NUM);
  assign err    = (state == FAIL);
  assign result = res;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: three parameterisations share one character stream and
// are checked against a token-level evaluator of the accepted prefix.
module tb_expr_eval;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h20;

  logic        o_v [3];
  logic        e_v [3];
  logic [31:0] r_v [3];
  logic [7:0]  res_w8;

  int cw [3] = '{32, 8, 32};
  int md [3] = '{4, 3, 4};
  bit am [3] = '{1'b1, 1'b1, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;
  byte hist[$];

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(32), .MAX_DIGITS(4), .ALLOW_MINUS(1)) u_main (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(o_v[0]), .err(e_v[0]), .result(r_v[0]));

  expr_eval #(.WIDTH(8), .MAX_DIGITS(3), .ALLOW_MINUS(1)) u_w8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(o_v[1]), .err(e_v[1]), .result(res_w8));

  expr_eval #(.WIDTH(32), .MAX_DIGITS(4), .ALLOW_MINUS(0)) u_nm (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .out(o_v[2]), .err(e_v[2]), .result(r_v[2]));

  assign r_v[1] = {24'b0, res_w8};

  typedef struct {
    string       s;
    int          dut;
    bit          o;
    bit          e;
    int unsigned r;
  } vec_t;

  vec_t tbl[$];

  function automatic bit is_dig(byte c);
    return (c >= 8'sh30) && (c <= 8'sh39);
  endfunction

  // Reference: find the first character that breaks the grammar, then
  // evaluate the longest digit-terminated prefix before it with precedence.
  function automatic void model(input byte s[$], input int w, input int maxd,
                                input bit allow_m, output bit o, output bit e,
                                output logic [31:0] r);
    int    f = -1;
    int    run = 0;
    int    n;
    longint nums[$];
    byte   ops[$];
    longint cur = 0;
    longint sum = 0;
    longint t;
    for (int i = 0; i < s.size(); i++) begin
      byte c = s[i];
      bit  isop = (c == "+") || (c == "*") || (allow_m && c == "-");
      if (is_dig(c)) begin
        run++;
        if (run > maxd) begin f = i; break; end
      end else if (isop && run > 0) begin
        run = 0;
      end else begin
        f = i; break;
      end
    end
    n = (f < 0) ? s.size() : f;
    if (n > 0 && !is_dig(s[n-1])) n--;
    for (int i = 0; i < n; i++) begin
      if (is_dig(s[i])) cur = cur * 10 + longint'(s[i] - 8'sh30);
      else begin nums.push_back(cur); ops.push_back(s[i]); cur = 0; end
    end
    if (n > 0) begin
      nums.push_back(cur);
      t = nums[0];
      for (int k = 0; k < ops.size(); k++) begin
        if (ops[k] == "*") t = t * nums[k+1];
        else begin
          sum = sum + t;
          t = (ops[k] == "-") ? -nums[k+1] : nums[k+1];
        end
      end
      sum = sum + t;
    end
    r = (w >= 32) ? sum[31:0] : (sum[31:0] & ((32'd1 << w) - 32'd1));
    e = (f >= 0);
    o = (f < 0) && (s.size() > 0) && is_dig(s[s.size()-1]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit v, input byte ch);
    @(negedge clk);
    clr = c;
    in_valid = v;
    in_ch = ch;
    @(posedge clk);
    #1;
    if (c) hist.delete();
    else if (v) hist.push_back(ch);
  endtask

  task automatic stream(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, s[i]);
  endtask

  task automatic check_all(input string tag);
    bit mo, me;
    logic [31:0] mr;
    for (int d = 0; d < 3; d++) begin
      model(hist, cw[d], md[d], am[d], mo, me, mr);
      chk($sformatf("%s dut%0d out", tag, d), {31'b0, o_v[d]}, {31'b0, mo});
      chk($sformatf("%s dut%0d err", tag, d), {31'b0, e_v[d]}, {31'b0, me});
      chk($sformatf("%s dut%0d result", tag, d), r_v[d], mr);
    end
  endtask

  initial begin
    int o_exp [6] = '{1, 1, 0, 1, 0, 1};
    int r_exp [6] = '{1, 12, 12, 15, 15, 24};
    string s0 = "12+3*4";

    tbl.push_back('{s:"12+3*4", dut:0, o:1, e:0, r:24});
    tbl.push_back('{s:"2*3-4",  dut:0, o:1, e:0, r:2});
    tbl.push_back('{s:"2*3-4",  dut:2, o:0, e:1, r:6});
    tbl.push_back('{s:"1++",    dut:0, o:0, e:1, r:1});
    tbl.push_back('{s:"*5",     dut:0, o:0, e:1, r:0});
    tbl.push_back('{s:"7a",     dut:0, o:0, e:1, r:7});
    tbl.push_back('{s:"7a9",    dut:0, o:0, e:1, r:7});
    tbl.push_back('{s:"1234",   dut:0, o:1, e:0, r:1234});
    tbl.push_back('{s:"12345",  dut:0, o:0, e:1, r:1234});
    tbl.push_back('{s:"0007",   dut:0, o:1, e:0, r:7});
    tbl.push_back('{s:"10+5*",  dut:0, o:0, e:0, r:15});
    tbl.push_back('{s:"200*2",  dut:1, o:1, e:0, r:144});
    tbl.push_back('{s:"3-5",    dut:1, o:1, e:0, r:254});
    tbl.push_back('{s:"1234",   dut:1, o:0, e:1, r:123});

    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset out dut%0d", d), {31'b0, o_v[d]}, 32'd0);
      chk($sformatf("reset err dut%0d", d), {31'b0, e_v[d]}, 32'd0);
      chk($sformatf("reset result dut%0d", d), r_v[d], 32'd0);
    end
    drive(1'b1, 1'b0, 8'h20);

    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, s0[i]);
      chk($sformatf("seq12 out[%0d]", i), {31'b0, o_v[0]}, o_exp[i]);
      chk($sformatf("seq12 result[%0d]", i), r_v[0], r_exp[i]);
      chk($sformatf("seq12 err[%0d]", i), {31'b0, e_v[0]}, 32'd0);
    end

    foreach (tbl[k]) begin
      drive(1'b1, 1'b0, 8'h20);
      stream(tbl[k].s);
      chk($sformatf("tbl%0d \"%s\" out", k, tbl[k].s), {31'b0, o_v[tbl[k].dut]}, {31'b0, tbl[k].o});
      chk($sformatf("tbl%0d \"%s\" err", k, tbl[k].s), {31'b0, e_v[tbl[k].dut]}, {31'b0, tbl[k].e});
      chk($sformatf("tbl%0d \"%s\" result", k, tbl[k].s), r_v[tbl[k].dut], tbl[k].r);
    end

    drive(1'b1, 1'b0, 8'h20);
    stream("4+");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, (i == 1) ? 8'h2b : 8'h35);
      chk($sformatf("hold out[%0d]", i), {31'b0, o_v[0]}, 32'd0);
      chk($sformatf("hold err[%0d]", i), {31'b0, e_v[0]}, 32'd0);
      chk($sformatf("hold result[%0d]", i), r_v[0], 32'd4);
    end
    stream("1");
    chk("after hold out", {31'b0, o_v[0]}, 32'd1);
    chk("after hold result", r_v[0], 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("async clr out", {31'b0, o_v[0]}, 32'd0);
    chk("async clr err", {31'b0, e_v[0]}, 32'd0);
    chk("async clr result", r_v[0], 32'd0);
    hist.delete();
    #1;
    clr = 1'b0;
    stream("8");
    chk("post clr out", {31'b0, o_v[0]}, 32'd1);
    chk("post clr result", r_v[0], 32'd8);

    drive(1'b1, 1'b0, 8'h20);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int  sel = $urandom_range(0, 99);
      bit  v = ($urandom_range(0, 9) < 8);
      bit  mo, me;
      logic [31:0] mr;
      byte ch;
      bit  c;
      string opsx = "+*-";
      string bad = "a /x=";
      model(hist, 32, 4, 1'b1, mo, me, mr);
      c = me ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
      if (sel < 60) ch = byte'(8'h30 + $urandom_range(0, 9));
      else if (sel < 92) ch = opsx[$urandom_range(0, 2)];
      else ch = bad[$urandom_range(0, 4)];
      drive(c, v, ch);
      check_all($sformatf("rand%0d", cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
